// File: rtl/inst_buffer_pkg.sv
// Shared widths and the stored entry type for the instruction buffer.
// The optional macro IBUF_BYPASS_EN is consumed by inst_buffer.sv.
`ifndef ICACHE_BANK
`define ICACHE_BANK 8
`endif
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif
`ifndef FSQ_WIDTH
`define FSQ_WIDTH 6
`endif

package inst_buffer_pkg;

  localparam int unsigned IBUF_BANK      = `ICACHE_BANK;
  localparam int unsigned IBUF_OUT_WIDTH = `FETCH_WIDTH;
  localparam int unsigned IBUF_IDX_WIDTH = `FSQ_WIDTH;

  typedef struct packed {
    logic [31:0]               inst;
    logic [`FSQ_WIDTH-1:0]     fsq_idx;
  } ibuf_entry_t;

endpackage

// File: rtl/ibuf_compact.sv
// Prefix popcount: per-slot offset (set bits below slot k) and total set bits.
module ibuf_compact
  import inst_buffer_pkg::*;
#(
  parameter int N = 8,
  localparam int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]         en,
  output logic [N-1:0][CW-1:0] offset,
  output logic [CW-1:0]        total
);

  logic [CW-1:0] acc;

  // Running sum gives each slot its compacted position.
  always_comb begin
    acc = '0;
    offset = '0;
    for (int k = 0; k < N; k++) begin
      offset[k] = acc;
      acc = acc + CW'(en[k]);
    end
    total = acc;
  end

endmodule

// File: rtl/inst_buffer.sv
// Instruction buffer: compacts sparse predecode groups into a circular FIFO
// and presents up to OUT_WIDTH oldest entries to decode.
// Optional macro IBUF_BYPASS_EN: an empty buffer forwards a new group to the
// outputs in the same cycle.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int BANK      = `ICACHE_BANK,
  parameter int OUT_WIDTH = `FETCH_WIDTH,
  parameter int IDX_WIDTH = `FSQ_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [BANK-1:0]                     pd_en,
  input  logic [$clog2(BANK)-1:0]             pd_num,
  input  logic [BANK-1:0][31:0]               pd_inst,
  input  logic [IDX_WIDTH-1:0]                pd_fsqIdx,
  output logic                                full,
  input  logic                                flush,
  input  logic                                dec_stall,
  output logic [OUT_WIDTH-1:0]                out_en,
  output logic [OUT_WIDTH-1:0][31:0]          out_inst,
  output logic [OUT_WIDTH-1:0][IDX_WIDTH-1:0] out_fsqIdx
);

  localparam int AW  = $clog2(DEPTH);
  localparam int WCW = $clog2(BANK + 1);
  localparam int RCW = $clog2(OUT_WIDTH + 1);
  localparam int OIW = $clog2(OUT_WIDTH);

  typedef logic [AW:0] ptr_t;

  ibuf_entry_t                    mem [DEPTH];
  ptr_t                           head, tail, count;
  ptr_t                           head_nxt, tail_nxt, count_nxt;
  logic [BANK-1:0][WCW-1:0]       wr_off;
  logic [WCW-1:0]                 wr_total;
  logic [WCW-1:0]                 wr_skip;
  logic [BANK-1:0]                wr_we;
  logic [BANK-1:0][AW-1:0]        wr_addr;
  logic                           wr_fire;
  logic [OUT_WIDTH-1:0]           rd_en;
  logic [OUT_WIDTH-1:0][RCW-1:0]  rd_off_unused;
  logic [RCW-1:0]                 rd_total;
  logic                           byp_act;
  logic                           unused_pd_num;

  // pd_num is redundant with pd_en; the popcount is recomputed locally.
  assign unused_pd_num = ^pd_num;

  assign count   = tail - head;
  assign wr_fire = (|pd_en) && !full && !flush && !rst;

  ibuf_compact #(.N(BANK)) u_wr_compact (
    .en     (pd_en),
    .offset (wr_off),
    .total  (wr_total)
  );

  ibuf_compact #(.N(OUT_WIDTH)) u_rd_count (
    .en     (rd_en),
    .offset (rd_off_unused),
    .total  (rd_total)
  );

  // Bypass only applies to an empty buffer; consumed slots skip the array.
`ifdef IBUF_BYPASS_EN
  always_comb begin
    byp_act = wr_fire && (count == '0);
    wr_skip = '0;
    if (byp_act && !dec_stall)
      wr_skip = (wr_total > WCW'(OUT_WIDTH)) ? WCW'(OUT_WIDTH) : wr_total;
  end
`else
  assign byp_act = 1'b0;
  assign wr_skip = '0;
`endif

  // Read window: oldest entries, optionally overridden by the bypass group.
  always_comb begin
    rd_en      = '0;
    out_inst   = '0;
    out_fsqIdx = '0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      rd_en[i]      = count > ptr_t'(i);
      out_inst[i]   = mem[head[AW-1:0] + AW'(i)].inst;
      out_fsqIdx[i] = mem[head[AW-1:0] + AW'(i)].fsq_idx;
    end
    out_en = rd_en;
    if (byp_act) begin
      out_en = '0;
      for (int k = 0; k < BANK; k++) begin
        if (pd_en[k] && (wr_off[k] < WCW'(OUT_WIDTH))) begin
          out_en[wr_off[k][OIW-1:0]]     = 1'b1;
          out_inst[wr_off[k][OIW-1:0]]   = pd_inst[k];
          out_fsqIdx[wr_off[k][OIW-1:0]] = pd_fsqIdx;
        end
      end
    end
  end

  // Per-slot write address and enable after compaction.
  always_comb begin
    wr_we   = '0;
    wr_addr = '0;
    for (int k = 0; k < BANK; k++) begin
      wr_we[k]   = wr_fire && pd_en[k] && (wr_off[k] >= wr_skip);
      wr_addr[k] = tail[AW-1:0] + AW'(wr_off[k]) - AW'(wr_skip);
    end
  end

  // Pointer update; flush and reset win over reads and writes.
  always_comb begin
    head_nxt = head;
    tail_nxt = tail;
    if (!dec_stall)
      head_nxt = head + ptr_t'(rd_total);
    if (wr_fire)
      tail_nxt = tail + ptr_t'(wr_total) - ptr_t'(wr_skip);
    if (flush || rst) begin
      head_nxt = '0;
      tail_nxt = '0;
    end
    count_nxt = tail_nxt - head_nxt;
  end

  // Pointer and backpressure registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      full <= 1'b0;
    end else begin
      head <= head_nxt;
      tail <= tail_nxt;
      full <= count_nxt > ptr_t'(DEPTH - BANK);
    end
  end

  // Entry array, not reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < BANK; k++) begin
      if (wr_we[k]) begin
        mem[wr_addr[k]].inst    <= pd_inst[k];
        mem[wr_addr[k]].fsq_idx <= pd_fsqIdx;
      end
    end
  end

endmodule
